// File: rtl/ecc_scalar_bit_sequencer.sv
// Presents a blinded ECC scalar to the ladder one bit per transfer, MSB first, constant-time.
// Load-to-first-valid 1 cycle; bit/idx/last hold while bit_ready_i is low; done_o pulses once after bit 0.
module ecc_scalar_bit_sequencer #(
   parameter  int REG_SIZE    = 384,
   parameter  int RND_SIZE    = 192,
   localparam int SCALAR_SIZE = REG_SIZE + RND_SIZE,
   localparam int IDX_W       = $clog2(SCALAR_SIZE)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   zeroize,
   input  logic                   load_i,
   input  logic [SCALAR_SIZE-1:0] scalar_i,
   input  logic                   bit_ready_i,
   output logic                   bit_valid_o,
   output logic                   bit_o,
   output logic [IDX_W-1:0]       bit_idx_o,
   output logic                   last_o,
   output logic                   busy_o,
   output logic                   done_o
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   logic [1:0]             state_q;
   logic [SCALAR_SIZE-1:0] shift_q;
   logic [IDX_W-1:0]       cnt_q;
   logic                   active;

   assign active = (state_q == ACTIVE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (zeroize) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load_i) begin
                  state_q <= ACTIVE;
                  shift_q <= scalar_i;
                  cnt_q   <= IDX_W'(SCALAR_SIZE - 1);
               end
            end
            ACTIVE: begin
               // Zero is shifted in so consumed scalar bits never linger in the register.
               if (bit_ready_i) begin
                  shift_q <= {shift_q[SCALAR_SIZE-2:0], 1'b0};
                  if (cnt_q == '0) begin
                     state_q <= DONE;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bit_valid_o = active;
   assign bit_o       = active & shift_q[SCALAR_SIZE-1];
   assign bit_idx_o   = active ? cnt_q : '0;
   assign last_o      = active & (cnt_q == '0);
   assign busy_o      = (state_q == ACTIVE) | (state_q == DONE);
   assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_ecc_scalar_bit_sequencer.sv
// Randomised and table-driven bench for ecc_scalar_bit_sequencer against an index-based stream model.
module tb_ecc_scalar_bit_sequencer;
   localparam int S   = 576;
   localparam int IW  = 10;
   localparam int BUDGET = 4000;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          zeroize = 1'b0;
   logic          load_i = 1'b0;
   logic [S-1:0]  scalar_i = '0;
   logic          bit_ready_i = 1'b0;
   logic          bit_valid_o, bit_o, last_o, busy_o, done_o;
   logic [IW-1:0] bit_idx_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [S-1:0] s;
      int           mode;     // 0 ready always, 1 toggle, 2 random
      int           inj;      // transfer count at which an all-ones load is pulsed, -1 none
      int           exp_cyc;  // load-cycle to done-cycle distance, -1 unchecked
   } vec_t;

   vec_t tbl[6];

   ecc_scalar_bit_sequencer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .zeroize    (zeroize),
      .load_i     (load_i),
      .scalar_i   (scalar_i),
      .bit_ready_i(bit_ready_i),
      .bit_valid_o(bit_valid_o),
      .bit_o      (bit_o),
      .bit_idx_o  (bit_idx_o),
      .last_o     (last_o),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   always #5 clk = ~clk;

   // {valid, bit, idx, last, done, busy}
   function automatic logic [14:0] outs();
      return {bit_valid_o, bit_o, bit_idx_o, last_o, done_o, busy_o};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [S-1:0] rnd_scalar();
      logic [S-1:0] v;
      for (int i = 0; i < S / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   localparam logic [14:0] IDLE_V = '0;
   localparam logic [14:0] DONE_V = 15'b0_0_0000000000_0_1_1;

   task automatic run_seq(input logic [S-1:0] s, input int mode, input int inj, input int exp_cyc);
      int   xf, k;
      logic rdy, injected, fin;
      logic [14:0] exp;
      load_i = 1'b1; scalar_i = s; bit_ready_i = 1'b0;
      @(posedge clk); #1;
      load_i = 1'b0; scalar_i = rnd_scalar();
      xf = 0; k = 1; injected = 1'b0; fin = 1'b0;
      while (!fin) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = k[0];
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         bit_ready_i = rdy;
         load_i = (!injected && xf == inj);
         scalar_i = load_i ? '1 : '0;
         if (load_i) injected = 1'b1;
         @(negedge clk);
         if (xf < S) begin
            exp = {1'b1, s[S-1-xf], IW'(S-1-xf), (xf == S-1), 1'b0, 1'b1};
            chk("stream", 64'(outs()), 64'(exp));
            if (rdy) xf++;
         end else begin
            chk("done_pulse", 64'(outs()), 64'(DONE_V));
            if (exp_cyc >= 0) chk("load_to_done", 64'(k), 64'(exp_cyc));
            chk("reg_wiped", 64'(dut.shift_q == '0), 64'd1);
            @(posedge clk); #1;
            load_i = 1'b0; bit_ready_i = 1'b0;
            @(negedge clk);
            chk("idle_after_done", 64'(outs()), 64'(IDLE_V));
            fin = 1'b1;
         end
         if (!fin) begin
            if (k > BUDGET) begin
               chk("seq_budget", 64'(k), 64'(BUDGET));
               fin = 1'b1;
            end
            @(posedge clk); #1;
            k++;
         end
      end
      load_i = 1'b0;
   endtask

   initial begin
      logic [S-1:0] msb_only;
      int guard;
      msb_only = '0; msb_only[S-1] = 1'b1;
      tbl[0] = '{s: S'(1),      mode: 0, inj: -1,  exp_cyc: 577};
      tbl[1] = '{s: msb_only,   mode: 1, inj: -1,  exp_cyc: 1152};
      tbl[2] = '{s: rnd_scalar(), mode: 2, inj: -1, exp_cyc: -1};
      tbl[3] = '{s: '0,         mode: 0, inj: 100, exp_cyc: 577};
      tbl[4] = '{s: rnd_scalar(), mode: 0, inj: 575, exp_cyc: 577};
      tbl[5] = '{s: '1,         mode: 2, inj: 576, exp_cyc: -1};

      #12;
      chk("reset_outputs", 64'(outs()), 64'(IDLE_V));
      @(negedge clk); reset_n = 1'b1;
      load_i = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", 64'(outs()), 64'(IDLE_V));
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) run_seq(tbl[i].s, tbl[i].mode, tbl[i].inj, tbl[i].exp_cyc);
      for (int i = 0; i < 3; i++) run_seq(rnd_scalar(), 2, -1, -1);

      // Zeroize when bit 300 is presented.
      load_i = 1'b1; scalar_i = rnd_scalar(); bit_ready_i = 1'b1;
      @(posedge clk); #1; load_i = 1'b0;
      guard = 0;
      @(negedge clk);
      while (bit_idx_o != IW'(300) && guard < BUDGET) begin
         @(negedge clk); guard++;
      end
      chk("reach_idx300", 64'(bit_idx_o), 64'd300);
      zeroize = 1'b1;
      @(posedge clk); #1; zeroize = 1'b0;
      @(negedge clk);
      chk("zeroize_idle", 64'(outs()), 64'(IDLE_V));
      chk("zeroize_wipe", 64'(dut.shift_q == '0), 64'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("zeroize_no_done", 64'(outs()), 64'(IDLE_V));
      end
      @(posedge clk); #1;
      run_seq(rnd_scalar(), 0, -1, 577);

      // Asynchronous reset in the middle of a sequence.
      load_i = 1'b1; scalar_i = '1; bit_ready_i = 1'b1;
      @(posedge clk); #1; load_i = 1'b0;
      repeat (50) @(posedge clk);
      #3; reset_n = 1'b0; #1;
      chk("async_reset_outs", 64'(outs()), 64'(IDLE_V));
      @(negedge clk); reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_reset_idle", 64'(outs()), 64'(IDLE_V));
      end
      @(posedge clk); #1;
      run_seq(rnd_scalar(), 2, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
